// File: rtl/ctrl_pkg.sv
// Shared control-path types for the ID/EX/MEM/WB pipeline.
// Holds the decoded control bundle, forwarding selects and opcodes.
package ctrl_pkg;

    localparam int CTRL_W = 10;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
        logic       jal_sel;
        logic       jalr_sel;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // A later stage can supply rs when it really writes a nonzero rd == rs.
    function automatic logic reg_hit(
        input logic             v,
        input logic             wr,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs
    );
        return v & wr & (rd != '0) & (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall, redirect priority, fwd selects.
// Ports: ID sources, EX/MEM/WB state in; stall, PC/IFID enables, flush, fwd out.
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_redirect,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b
);

    logic load_use;

    always_comb begin
        load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid
                 & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        // The redirect kills the dependent ID instruction anyway.
        stall      = load_use & ~ex_redirect;
        pc_write   = ~stall;
        ifid_write = ~stall;
        ifid_flush = ex_redirect;

        fwd_a = FWD_RF;
        if (reg_hit(mem_valid, mem_reg_write, mem_rd, ex_rs1)) begin
            fwd_a = FWD_MEM;
        end else if (reg_hit(wb_valid, wb_reg_write, wb_rd, ex_rs1)) begin
            fwd_a = FWD_WB;
        end

        fwd_b = FWD_RF;
        if (reg_hit(mem_valid, mem_reg_write, mem_rd, ex_rs2)) begin
            fwd_b = FWD_MEM;
        end else if (reg_hit(wb_valid, wb_reg_write, wb_rd, ex_rs2)) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB registers, bubbles, flush, counters.
// Ports: clk/reset_n, ID bundle + redirect in; stage bundles, fwd, enables out.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_redirect,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  mem_rd,
    output logic [REG_W-1:0]  wb_rd,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    ctrl_t            mem_ctrl_q, mem_ctrl_d;
    ctrl_t            wb_ctrl_q, wb_ctrl_d;
    logic [REG_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             ex_valid_q, ex_valid_d;
    logic             mem_valid_q, mem_valid_d;
    logic             wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     stall;
    logic     flush;
    fwd_sel_t fwd_a_s;
    fwd_sel_t fwd_b_s;

    hazard_unit u_hazard (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_redirect   (ex_redirect),
        .ex_valid      (ex_valid_q),
        .ex_mem_read   (ex_ctrl_q.mem_read),
        .ex_rd         (ex_rd_q),
        .ex_rs1        (ex_rs1_q),
        .ex_rs2        (ex_rs2_q),
        .mem_valid     (mem_valid_q),
        .mem_reg_write (mem_ctrl_q.reg_write),
        .mem_rd        (mem_rd_q),
        .wb_valid      (wb_valid_q),
        .wb_reg_write  (wb_ctrl_q.reg_write),
        .wb_rd         (wb_rd_q),
        .stall         (stall),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (flush),
        .fwd_a         (fwd_a_s),
        .fwd_b         (fwd_b_s)
    );

    always_comb begin
        // ID/EX defaults to a fully zeroed bubble.
        ex_valid_d = 1'b0;
        ex_ctrl_d  = CTRL_NOP;
        ex_rd_d    = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        if (id_valid && !stall && !ex_redirect) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = ctrl_t'(id_ctrl);
            ex_rd_d    = id_rd;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
        end

        // The redirecting instruction itself still moves on to MEM.
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_rd_d     = mem_rd_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_NOP;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= CTRL_NOP;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= CTRL_NOP;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign mem_ctrl   = mem_ctrl_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;
    assign ex_rd      = ex_rd_q;
    assign mem_rd     = mem_rd_q;
    assign wb_rd      = wb_rd_q;
    assign ex_valid   = ex_valid_q;
    assign mem_valid  = mem_valid_q;
    assign wb_valid   = wb_valid_q;
    assign fwd_a      = fwd_a_s;
    assign fwd_b      = fwd_b_s;
    // No kill request may leave the block while it is held in reset.
    assign ifid_flush = flush & reset_n;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus random traffic vs a model.
// Two instances share stimulus: default width and a 4-bit counter width.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [9:0] id_ctrl;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect;

    logic [9:0]  ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_valid, mem_valid, wb_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, ifid_flush;
    logic [31:0] stall_cnt, flush_cnt;

    logic [9:0]  s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd, s_mem_rd, s_wb_rd;
    logic        s_ex_valid, s_mem_valid, s_wb_valid;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_pc_write, s_ifid_write, s_ifid_flush;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
        .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
        .ex_valid(s_ex_valid), .mem_valid(s_mem_valid),
        .wb_valid(s_wb_valid),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    localparam logic [9:0] LW  = 10'b11_1_1_0_00_000;
    localparam logic [9:0] ADD = 10'b00_1_0_0_10_000;

    // Model: instructions in flight, index 0=EX, 1=MEM, 2=WB.
    typedef struct packed {
        logic       v;
        logic [9:0] c;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    ins_t m [3];
    int   m_stalls;
    int   m_flushes;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic writes(input ins_t i, input logic [4:0] rs);
        return i.v && i.c[7] && i.rd != 5'd0 && i.rd == rs;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (writes(m[1], rs)) return 2'b10;
        if (writes(m[2], rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        logic lu;
        lu = m[0].v && m[0].c[6] && m[0].rd != 5'd0 && id_valid
             && (m[0].rd == id_rs1 || m[0].rd == id_rs2);
        return lu && !ex_redirect && reset_n;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic model_advance();
        logic st;
        if (!reset_n) begin
            model_reset();
            return;
        end
        st = model_stall();
        m[2] = m[1];
        m[1] = m[0];
        if (id_valid && !st && !ex_redirect)
            m[0] = '{1'b1, id_ctrl, id_rd, id_rs1, id_rs2};
        else
            m[0] = '0;
        if (st) m_stalls++;
        if (ex_redirect) m_flushes++;
    endtask

    task automatic check_model();
        logic st;
        st = model_stall();
        chk("ex_valid", ex_valid, m[0].v);
        chk("ex_ctrl", ex_ctrl, m[0].c);
        chk("ex_rd", ex_rd, m[0].rd);
        chk("ex_rs1", ex_rs1, m[0].rs1);
        chk("ex_rs2", ex_rs2, m[0].rs2);
        chk("mem_valid", mem_valid, m[1].v);
        chk("mem_ctrl", mem_ctrl, m[1].c);
        chk("mem_rd", mem_rd, m[1].rd);
        chk("wb_valid", wb_valid, m[2].v);
        chk("wb_ctrl", wb_ctrl, m[2].c);
        chk("wb_rd", wb_rd, m[2].rd);
        chk("fwd_a", fwd_a, exp_fwd(m[0].rs1));
        chk("fwd_b", fwd_b, exp_fwd(m[0].rs2));
        chk("pc_write", pc_write, !st);
        chk("ifid_write", ifid_write, !st);
        chk("ifid_flush", ifid_flush, ex_redirect && reset_n);
        chk("stall_cnt", stall_cnt, m_stalls);
        chk("flush_cnt", flush_cnt, m_flushes);
        chk("s_stall_cnt", s_stall_cnt, sat(m_stalls, 15));
        chk("s_flush_cnt", s_flush_cnt, sat(m_flushes, 15));
        chk("s_fwd_b", s_fwd_b, exp_fwd(m[0].rs2));
        chk("s_wb_ctrl", s_wb_ctrl, m[2].c);
    endtask

    task automatic tick();
        #1;
        check_model();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] c,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic redir);
        id_valid    = v;
        id_ctrl     = c;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        ex_redirect = redir;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;

        // Empty pipeline after reset.
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_pc_write", pc_write, 1'b1);
        chk("rst_stall_cnt", stall_cnt, 32'd0);

        // Load-use: lw x5 then add using x5.
        drive(1'b1, LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd6, 5'd8, 1'b0);
        #1;
        chk("lu_pc_write", pc_write, 1'b0);
        chk("lu_ifid_write", ifid_write, 1'b0);
        tick();
        #1;
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_mem_ctrl", mem_ctrl, LW);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_resume", pc_write, 1'b1);
        tick();
        #1;
        chk("lu_ex_rs1", ex_rs1, 5'd5);

        // Forwarding priority: two writers of x3, then a reader.
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        tick();
        drive(1'b1, ADD, 5'd4, 5'd3, 5'd9, 1'b0);
        tick();
        #1;
        chk("prio_fwd_b", fwd_b, 2'b10);
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd4, 1'b0);
        tick();
        #1;
        chk("x0_fwd_a", fwd_a, 2'b00);
        chk("x0_fwd_b", fwd_b, 2'b00);

        // Redirect beats a concurrent load-use stall.
        drive(1'b1, LW, 5'd2, 5'd0, 5'd7, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd7, 5'd1, 5'd6, 1'b1);
        #1;
        chk("rb_ifid_flush", ifid_flush, 1'b1);
        chk("rb_pc_write", pc_write, 1'b1);
        tick();
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rb_mem_ctrl", mem_ctrl, LW);
        chk("rb_ex_valid", ex_valid, 1'b0);
        chk("rb_stall_cnt", stall_cnt, 32'd1);
        chk("rb_flush_cnt", flush_cnt, 32'd1);

        // Counter saturation on the narrow instance.
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("sat_flush_s", s_flush_cnt, 4'd15);
        chk("sat_flush", flush_cnt, 32'd21);

        // Reset asserted in the middle of a stall.
        drive(1'b1, LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd5, 5'd8, 1'b0);
        #1;
        chk("ms_stall", pc_write, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("ms_ex_valid", ex_valid, 1'b0);
        chk("ms_mem_valid", mem_valid, 1'b0);
        chk("ms_mem_ctrl", mem_ctrl, 10'd0);
        chk("ms_pc_write", pc_write, 1'b1);
        chk("ms_stall_cnt", stall_cnt, 32'd0);
        chk("ms_flush_cnt", flush_cnt, 32'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
        #1;
        chk("ms_advance", ex_valid, 1'b1);
        chk("ms_ex_rd", ex_rd, 5'd8);

        // Random traffic with small register space to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] c;
            c    = 10'($urandom);
            c[6] = ($urandom_range(0, 9) < 4);
            drive($urandom_range(0, 3) != 0, c,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
            tick();
        end
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
